pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised fetch program-counter generator; successor to the single-mux PC register in the core front end.
- Adds configurable width, reset vector and step size, two-level redirect priority (trap over branch), stall handling with a pending-redirect buffer, and a valid/ready fetch handshake.
- Sits between the execute/trap logic (redirect sources) and the instruction memory port.

Parameters:
- XLEN, 32, width of all PC/target buses.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes (power of two, 2 or 4).
- TRAP_VECTOR, 32'h0000_0100, redirect target for misaligned redirects (used only with the optional feature).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freeze PC; no advance, no handshake acceptance.
- pcsrc  in  1  branch/jump redirect request, single-cycle qualifier.
- i_pc_target  in  XLEN  branch/jump target.
- trap  in  1  trap redirect request; has priority over pcsrc.
- i_trap_target  in  XLEN  trap handler address.
- i_fetch_ready  in  1  instruction memory accepts the current o_pc.
- o_pc  out  XLEN  current fetch address.
- o_pc4  out  XLEN  o_pc + STEP, modulo 2^XLEN (combinational from the PC register).
- o_fetch_valid  out  1  o_pc is a live fetch request.
- o_redirect_pending  out  1  a redirect is buffered during a stall.
- o_misaligned  out  1  one-cycle pulse: redirect target misaligned (optional feature only; tied 0 otherwise).

Behaviour:
- Reset is synchronous, active-high, and dominates all inputs:
  - o_pc=RESET_VECTOR; o_fetch_valid=0; o_redirect_pending=0; o_misaligned=0; state=BOOT; pending register cleared.
- States and transitions:
  - BOOT: valid=0 for exactly one cycle after reset deasserts, then RUN. A redirect seen in BOOT loads the target and still enters RUN.
  - RUN: valid=1.
  - PEND: valid=0; a redirect is buffered.
- Redirect select:
  - eff_redirect = trap | pcsrc.
  - eff_target = trap ? i_trap_target : i_pc_target.
  - Without the feature, target low log2(STEP) bits are forced to 0.
- RUN, stall=0, eff_redirect=1:
  - o_pc <= eff_target next cycle, regardless of i_fetch_ready.
  - The unaccepted old fetch is abandoned; valid stays 1.
- RUN, stall=0, no redirect:
  - Advance o_pc <= o_pc4 only if i_fetch_ready=1.
  - Otherwise hold o_pc; valid stays 1 and the address stays stable.
- RUN, stall=1:
  - o_pc held; handshake not accepted even if i_fetch_ready=1.
  - Redirect in the same cycle: target captured into the pending register with a trap/branch tag; o_redirect_pending<=1; state PEND.
- PEND, stall=1, new redirect:
  - A trap overwrites any pending entry.
  - A branch overwrites only a pending branch; a pending trap is kept.
- PEND, stall=0:
  - o_pc <= pending target; clear pending; state RUN; valid=1 the following cycle.
  - A redirect arriving in this same cycle overrides the pending target and follows the same priority rule.
- Wrap-around: o_pc4 and sequential advance wrap modulo 2^XLEN.
  - XLEN=32, STEP=4: 32'hFFFF_FFFC -> 32'h0000_0000; no flag raised.
- Simultaneous trap+pcsrc: trap wins; the branch is dropped.
- Reset mid-PEND or mid-stall: pending contents are discarded; the BOOT sequence restarts.
- The handshake never changes o_pc while o_fetch_valid=1 and i_fetch_ready=0, except on a redirect.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect target with nonzero low log2(STEP) bits is not taken.
  - o_pc loads TRAP_VECTOR instead, and o_misaligned pulses high for one cycle, coincident with the load.
  - A misaligned target captured in PEND is checked when applied.
- Undefined:
  - Low bits are silently cleared.
  - o_misaligned is constant 0.

Test Plan:
- Reset, then release with ready=1: cycle0 o_pc=0, valid=0; cycle1 valid=1, o_pc=0; cycle2 o_pc=4; o_pc4=8.
- ready=0 for 3 cycles at o_pc=0x10: o_pc holds 0x10, valid=1; ready=1 -> next o_pc=0x14.
- trap=1 (target 0x200) and pcsrc=1 (target 0x80) in the same cycle: next o_pc=0x200.
- stall=1 with pcsrc target 0x40, then trap target 0x300 while stalled, then branch 0x60: pending=1, o_pc frozen, valid=0; stall=0 -> o_pc=0x300.
- o_pc=0xFFFF_FFFC, ready=1: next o_pc=0x0000_0000, o_pc4 was 0x0000_0000.
- With PC_MISALIGN_TRAP_EN, pcsrc target 0x42: o_pc=TRAP_VECTOR (0x100), o_misaligned=1 for one cycle. Without the macro: o_pc=0x40, o_misaligned=0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: reset vector, sequential step, trap/branch redirects,
// stall-time redirect buffering and a valid/ready fetch handshake. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              STEP         = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] i_pc_target,
    input  logic            trap,
    input  logic [XLEN-1:0] i_trap_target,
    input  logic            i_fetch_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc4,
    output logic            o_fetch_valid,
    output logic            o_redirect_pending,
    output logic            o_misaligned
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);
    localparam logic [XLEN-1:0] STEP_INC = XLEN'(STEP);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pend_target_reg, pend_target_next;
    logic            pend_trap_reg, pend_trap_next;
    logic            mis_reg, mis_next;

    logic            eff_redirect;
    logic [XLEN-1:0] eff_target;
    logic            load_en;
    logic [XLEN-1:0] load_target;

    assign eff_redirect = trap | pcsrc;
    assign eff_target   = trap ? i_trap_target : i_pc_target;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_target_next = pend_target_reg;
        pend_trap_next   = pend_trap_reg;
        mis_next         = 1'b0;
        load_en          = 1'b0;
        load_target      = eff_target;

        case (state_reg)
            BOOT: begin
                load_en    = eff_redirect;
                state_next = RUN;
            end
            RUN: begin
                if (stall) begin
                    if (eff_redirect) begin
                        pend_target_next = eff_target;
                        pend_trap_next   = trap;
                        state_next       = PEND;
                    end
                end else if (eff_redirect) begin
                    load_en = 1'b1;
                end else if (i_fetch_ready) begin
                    pc_next = pc_reg + STEP_INC;
                end
            end
            PEND: begin
                // A buffered trap can only be displaced by a newer trap.
                if (trap) begin
                    pend_target_next = i_trap_target;
                    pend_trap_next   = 1'b1;
                end else if (pcsrc && !pend_trap_reg) begin
                    pend_target_next = i_pc_target;
                    pend_trap_next   = 1'b0;
                end
                if (!stall) begin
                    load_en          = 1'b1;
                    load_target      = pend_target_next;
                    pend_target_next = '0;
                    pend_trap_next   = 1'b0;
                    state_next       = RUN;
                end
            end
            default: state_next = BOOT;
        endcase

        if (load_en) begin
`ifdef PC_MISALIGN_TRAP_EN
            if ((load_target & LOW_MASK) != '0) begin
                pc_next  = TRAP_VECTOR;
                mis_next = 1'b1;
            end else begin
                pc_next = load_target;
            end
`else
            pc_next = load_target & ~LOW_MASK;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_VECTOR;
            pend_target_reg <= '0;
            pend_trap_reg   <= 1'b0;
            mis_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_target_reg <= pend_target_next;
            pend_trap_reg   <= pend_trap_next;
            mis_reg         <= mis_next;
        end
    end

`ifndef PC_MISALIGN_TRAP_EN
    // The trap vector only matters when misaligned redirects are trapped.
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
`endif

    assign o_pc               = pc_reg;
    assign o_pc4              = pc_reg + STEP_INC;
    assign o_fetch_valid      = (state_reg == RUN);
    assign o_redirect_pending = (state_reg == PEND);
    assign o_misaligned       = mis_reg;

endmodule
